// File: rtl/mux8_rr_sched_pkg.sv
// Shared types and helpers for the 8-way round-robin select scheduler.
// Holds the requester count, select width, FSM state type and one-hot decode.
package mux_sched_pkg;
  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot3(input logic [SEL_W-1:0] s);
    onehot3    = '0;
    onehot3[s] = 1'b1;
  endfunction
endpackage

// File: rtl/mux8_rr_sched_if.sv
// Bundle of requester inputs, consumer handshake and scheduler status for mux8_rr_sched.
// The master side (requesters and consumer) drives req/lock/din/o_ready; the scheduler is the slave.
interface mux8_rr_sched_if #(
  parameter int W = 32
);
  import mux_sched_pkg::*;

  // Handshake: a word moves in any cycle with o_valid & o_ready; while o_valid & ~o_ready,
  // o_valid/o_data/o_src hold. gnt pulses one-hot to the owner in exactly that cycle.
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   lock;
  logic [N_REQ*W-1:0] din;
  logic               o_ready;
  logic               o_valid;
  logic [W-1:0]       o_data;
  logic [SEL_W-1:0]   o_src;
  logic [SEL_W-1:0]   sel;
  logic [N_REQ-1:0]   gnt;
  logic               busy;
  state_t             dbg_state;

  modport master (
    output req, lock, din, o_ready,
    input  o_valid, o_data, o_src, sel, gnt, busy, dbg_state
  );

  modport slave (
    input  req, lock, din, o_ready,
    output o_valid, o_data, o_src, sel, gnt, busy, dbg_state
  );
endinterface

// File: rtl/mux8_rr_sched_rr_pick8.sv
// Combinational round-robin picker: first set candidate at or after ptr, wrapping mod 8.
// Rotates the candidates so ptr lands at bit 0, takes the lowest set bit, then rotates back.
module rr_pick8
  import mux_sched_pkg::*;
(
  input  logic [N_REQ-1:0] i_cand,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_found,
  output logic [SEL_W-1:0] o_idx
);
  logic [N_REQ-1:0] w_rot;
  logic [SEL_W-1:0] w_off;

  always_comb begin
    w_rot = '0;
    w_off = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_rot[k] = i_cand[SEL_W'(i_ptr + SEL_W'(k))];
    end
    // Descending scan so the lowest rotated index wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = SEL_W'(k);
    end
    o_found = |i_cand;
    o_idx   = i_ptr + w_off;
  end
endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler sharing one 8:1 W-bit select path among 8 requesters,
// with optional per-requester lock for bursts capped at LOCK_MAX beats.
module mux8_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int W        = 32,
  parameter int LOCK_MAX = 16
) (
  input logic             clk,
  input logic             rst_n,
  mux8_rr_sched_if.slave  bus
);
  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_beat_cnt;

  state_t           w_state_nxt;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [SEL_W-1:0] w_ptr_nxt;
  logic [CNT_W-1:0] w_beat_cnt_nxt;

  logic [N_REQ-1:0] w_owner_oh;
  logic             w_in_xfer;
  logic             w_valid;
  logic             w_hs;
  logic             w_keep;
  logic [N_REQ-1:0] w_cand;
  logic             w_found;
  logic [SEL_W-1:0] w_idx;
  logic             w_do_pick;

  assign w_owner_oh = onehot3(r_sel);
  assign w_in_xfer  = (r_state == XFER);
  assign w_valid    = w_in_xfer & bus.req[r_sel];
  assign w_hs       = w_valid & bus.o_ready;
  // Lock holds the owner unless this handshake is the last allowed beat of the tenure.
  assign w_keep     = bus.lock[r_sel] & ~(w_hs & (r_beat_cnt == CNT_LAST));
  // On release the current owner is masked for this pick only.
  assign w_cand     = w_in_xfer ? (bus.req & ~w_owner_oh) : bus.req;

  rr_pick8 u_pick (
    .i_cand  (w_cand),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_ptr      <= w_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_ptr_nxt      = r_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    w_do_pick      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_do_pick   = 1'b1;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (w_keep) begin
          if (w_hs) w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
        end else if (w_hs | ~bus.req[r_sel]) begin
          if (w_found) w_do_pick   = 1'b1;
          else         w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_do_pick) begin
      w_sel_nxt      = w_idx;
      w_ptr_nxt      = w_idx + SEL_W'(1);
      w_beat_cnt_nxt = '0;
    end
  end

  always_comb begin
    bus.o_valid   = w_valid;
    bus.gnt       = w_hs ? w_owner_oh : '0;
    bus.busy      = w_in_xfer;
    bus.o_src     = r_sel;
    bus.sel       = r_sel;
    bus.dbg_state = r_state;
    case (r_sel)
      3'd0:    bus.o_data = bus.din[0*W +: W];
      3'd1:    bus.o_data = bus.din[1*W +: W];
      3'd2:    bus.o_data = bus.din[2*W +: W];
      3'd3:    bus.o_data = bus.din[3*W +: W];
      3'd4:    bus.o_data = bus.din[4*W +: W];
      3'd5:    bus.o_data = bus.din[5*W +: W];
      3'd6:    bus.o_data = bus.din[6*W +: W];
      3'd7:    bus.o_data = bus.din[7*W +: W];
      default: bus.o_data = bus.din[0*W +: W];
    endcase
  end
endmodule

// File: tb/tb_mux8_rr_sched.sv
// Bench for mux8_rr_sched: directed scenarios then random traffic, each cycle compared
// against a cycle-level reference model of the arbitration rules plus a word scoreboard.
module tb_mux8_rr_sched;
  import mux_sched_pkg::*;

  localparam int W  = 32;
  localparam int LM = 4;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux8_rr_sched_if #(.W(W)) bus();

  mux8_rr_sched #(.W(W), .LOCK_MAX(LM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] din_a[8];

  // reference model: owner -1 means no owner (idle)
  int         m_owner;
  int         m_sel;
  int         m_ptr;
  int         m_beats;
  logic [7:0] m_last_gnt;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner    = -1;
    m_sel      = 0;
    m_ptr      = 0;
    m_beats    = 0;
    m_last_gnt = 8'h00;
    exp_q.delete();
  endtask

  function automatic int pick(input logic [7:0] cand, input int ptr);
    for (int k = 0; k < 8; k++) begin
      if (cand[(ptr + k) % 8]) return (ptr + k) % 8;
    end
    return -1;
  endfunction

  task automatic take(input int w);
    m_owner = w;
    m_sel   = w;
    m_ptr   = (w + 1) % 8;
    m_beats = 0;
  endtask

  // driver: apply one cycle of inputs, compare, then advance the model across the posedge
  task automatic step(input logic [7:0] rq, input logic [7:0] lk, input logic rdy);
    logic       e_valid;
    logic       e_hs;
    logic [7:0] e_gnt;
    int         w;
    @(negedge clk);
    bus.req     = rq;
    bus.lock    = lk;
    bus.o_ready = rdy;
    for (int i = 0; i < 8; i++) bus.din[i*W +: W] = din_a[i];
    #1;
    e_valid = (m_owner >= 0) ? rq[m_owner] : 1'b0;
    e_hs    = e_valid & rdy;
    e_gnt   = e_hs ? (8'd1 << m_owner) : 8'd0;
    check("o_valid", W'(bus.o_valid), W'(e_valid));
    check("gnt",     W'(bus.gnt),     W'(e_gnt));
    check("busy",    W'(bus.busy),    W'(m_owner >= 0));
    check("o_src",   W'(bus.o_src),   W'(m_sel));
    check("sel",     W'(bus.sel),     W'(m_sel));
    if (e_valid) check("o_data", bus.o_data, din_a[m_sel]);
    if (e_hs) exp_q.push_back(din_a[m_sel]);
    if (bus.o_valid === 1'b1 && rdy) begin
      check("sb_pending", W'(exp_q.size() != 0), W'(1));
      if (exp_q.size() != 0) check("sb_word", bus.o_data, exp_q.pop_front());
    end
    m_last_gnt = e_gnt;
    if (m_owner < 0) begin
      w = pick(rq, m_ptr);
      if (w >= 0) take(w);
    end else begin
      if (e_hs) m_beats++;
      if (lk[m_owner] && !(e_hs && m_beats == LM)) begin
        // locked owner keeps the bus (including burst gaps)
      end else if (e_hs || !rq[m_owner]) begin
        w = pick(rq & ~(8'd1 << m_owner), m_ptr);
        if (w >= 0) take(w);
        else m_owner = -1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.o_ready = 1'b1;
    rst_n       = 1'b0;
    #1;
    check("rst_o_valid", W'(bus.o_valid), W'(0));
    check("rst_gnt",     W'(bus.gnt),     W'(0));
    check("rst_busy",    W'(bus.busy),    W'(0));
    check("rst_sel",     W'(bus.sel),     W'(0));
    check("rst_o_src",   W'(bus.o_src),   W'(0));
    bus.req     = '0;
    bus.lock    = '0;
    bus.o_ready = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic refresh_granted();
    for (int i = 0; i < 8; i++) if (m_last_gnt[i]) din_a[i] = $urandom;
  endtask

  logic [7:0] rq_cur;
  logic [7:0] lk_cur;
  logic       rdy_cur;

  initial begin
    bus.req     = '0;
    bus.lock    = '0;
    bus.o_ready = 1'b0;
    bus.din     = '0;
    for (int i = 0; i < 8; i++) din_a[i] = $urandom;
    model_reset();
    @(posedge clk);
    do_reset();

    // reset while a word is offered
    step(8'h01, 8'h00, 1'b0);
    step(8'h01, 8'h00, 1'b0);
    check("pre_rst_valid", W'(bus.o_valid), W'(1));
    do_reset();

    // single requester re-wins after one idle cycle
    din_a[2] = 32'h0000_2222;
    repeat (6) begin
      step(8'h04, 8'h00, 1'b1);
      refresh_granted();
    end

    // all requesting, no lock: owners rotate back-to-back
    do_reset();
    repeat (12) begin
      step(8'hFF, 8'h00, 1'b1);
      refresh_granted();
    end

    // backpressure on owner 3
    do_reset();
    din_a[3] = 32'hDEADBEEF;
    repeat (6) step(8'h08, 8'h00, 1'b0);
    check("bp_data", bus.o_data, 32'hDEADBEEF);
    step(8'h08, 8'h00, 1'b1);
    check("bp_gnt", W'(bus.gnt), W'(8'h08));
    step(8'h00, 8'h00, 1'b1);

    // lock cap: 4 beats from 0, then 5, then 0
    do_reset();
    repeat (10) begin
      step(8'h21, 8'h01, 1'b1);
      refresh_granted();
    end

    // withdrawal with wrap: 7 drops, 1 takes over
    do_reset();
    step(8'h80, 8'h00, 1'b0);
    step(8'h80, 8'h00, 1'b0);
    step(8'h02, 8'h00, 1'b0);
    step(8'h02, 8'h00, 1'b1);
    check("wd_owner", W'(bus.o_src), W'(1));
    step(8'h02, 8'h00, 1'b1);
    step(8'h02, 8'h00, 1'b1);

    // random traffic respecting the requester hold rule
    do_reset();
    rq_cur = '0;
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        do_reset();
        rq_cur = '0;
      end
      for (int i = 0; i < 8; i++) begin
        if (rq_cur[i] && !m_last_gnt[i]) begin
          if ($urandom_range(0, 15) == 0) rq_cur[i] = 1'b0;
        end else begin
          rq_cur[i] = 1'($urandom_range(0, 1));
          din_a[i]  = $urandom;
        end
        lk_cur[i] = ($urandom_range(0, 3) == 0);
      end
      rdy_cur = ($urandom_range(0, 3) != 0);
      step(rq_cur, lk_cur, rdy_cur);
    end
    check("sb_drain", W'(exp_q.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
